add_wb_buffer: RTL

ADD_WB_BUFFER -- requirements
Module: add_wb_buffer

---
 rtl/add_wb_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/add_wb_buffer.sv
// add_wb_buffer: small show-ahead FIFO that holds adder results until the
// register file accepts them. Each entry is {carry, sum[15:0], tag}.
// Also counts accepted results whose carry-out was set (saturating at 255).
// Optional build macro ADD_WB_SAT_EN: clamp wb_data to 16'hFFFF when the head
// entry carries; otherwise wb_data is the wrapped 16-bit sum.
module add_wb_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [16:0]              in_sum,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     in_ready,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [15:0]              wb_data,
  output logic [TAG_W-1:0]         wb_tag,
  output logic                     wb_carry,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               carry_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 17 + TAG_W;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      carry_cnt_q, carry_cnt_d;
  logic            push, pop;
  logic [EntW-1:0] head;
  logic [15:0]     head_sum;

  // Handshakes derive only from registered count: a full buffer never takes a
  // push, even in a cycle that also pops.
  assign in_ready = (count_q < FullCnt);
  assign wb_valid = (count_q != '0);
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;

  // Next-state for pointers, occupancy and the carry counter
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    carry_cnt_d = carry_cnt_q;
    // Pointers wrap naturally because DEPTH is a power of two
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (push && in_sum[16] && (carry_cnt_q != 8'hFF)) begin
      carry_cnt_d = carry_cnt_q + 8'd1;
    end
  end

  // Control state register; reset wins over any push or pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      carry_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  // Entry storage; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= {in_sum, in_tag};
    end
  end

  // Show-ahead read of the head entry
  always_comb begin
    head     = mem_q[rd_ptr_q];
    head_sum = head[TAG_W +: 16];
    wb_tag   = head[TAG_W-1:0];
    wb_carry = head[EntW-1];
`ifdef ADD_WB_SAT_EN
    wb_data  = wb_carry ? 16'hFFFF : head_sum;
`else
    wb_data  = head_sum;
`endif
  end

  assign count     = count_q;
  assign carry_cnt = carry_cnt_q;

endmodule
